// File: rtl/mux_tree_pipe.sv
// rtl/mux_tree_pipe.sv - pipelined N:1 mux tree with valid/ready handshake and optional round-robin select
module mux_tree_pipe #(
    parameter int WIDTH   = 8,
    parameter int N_IN    = 8,
    parameter int SEL_W   = $clog2(N_IN),
    parameter int RR_MODE = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_IN*WIDTH-1:0] in,
    input  logic [SEL_W-1:0]      sel,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WIDTH-1:0]      out,
    output logic [SEL_W-1:0]      out_sel,
    output logic                  out_valid,
    input  logic                  out_ready
);
    localparam int L = SEL_W;

    // All tree nodes packed level by level: level k occupies node[N_IN-(N_IN>>k) +: N_IN>>(k+1)]
    logic [WIDTH-1:0] node [N_IN-1];
    logic [SEL_W-1:0] tag  [L];
    logic             v    [L];
    logic [L:0]       ld;
    logic [SEL_W-1:0] sel_eff;

    // A stage may load when empty or when the stage after it is loading this cycle
    always_comb begin
        ld    = '0;
        ld[L] = out_ready;
        for (int k = L - 1; k >= 0; k--) begin
            ld[k] = !v[k] || ld[k+1];
        end
    end

    assign in_ready  = ld[0];
    assign out_valid = v[L-1];
    assign out       = node[N_IN-2];
    assign out_sel   = tag[L-1];

    for (genvar k = 0; k < L; k++) begin : g_lvl
        localparam int NO = N_IN >> (k + 1);
        localparam int OB = N_IN - (N_IN >> k);
        localparam int IB = (k == 0) ? 0 : N_IN - ((2 * N_IN) >> k);

        logic [WIDTH-1:0] src [2*NO];
        logic [SEL_W-1:0] tin;
        logic             vin;

        if (k == 0) begin : g_first
            for (genvar j = 0; j < 2 * NO; j++) begin : g_src
                assign src[j] = in[j*WIDTH +: WIDTH];
            end
            assign tin = sel_eff;
            assign vin = in_valid;
        end else begin : g_next
            for (genvar j = 0; j < 2 * NO; j++) begin : g_src
                assign src[j] = node[IB+j];
            end
            assign tin = tag[k-1];
            assign vin = v[k-1];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v[k]   <= 1'b0;
                tag[k] <= '0;
                for (int j = 0; j < NO; j++) begin
                    node[OB+j] <= '0;
                end
            end else if (ld[k]) begin
                v[k]   <= vin;
                tag[k] <= tin;
                for (int j = 0; j < NO; j++) begin
                    node[OB+j] <= tin[k] ? src[2*j+1] : src[2*j];
                end
            end
        end
    end

    if (RR_MODE != 0) begin : g_rr
        logic [SEL_W-1:0] rr_ptr;
        logic             unused_sel;

        assign unused_sel = ^sel;
        assign sel_eff    = rr_ptr;

        // Power-of-two channel count makes the natural wrap the required N_IN-1 -> 0 wrap
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rr_ptr <= '0;
            end else if (in_valid && in_ready) begin
                rr_ptr <= rr_ptr + 1'b1;
            end
        end
    end else begin : g_ext
        assign sel_eff = sel;
    end

endmodule

// File: tb/tb_mux_tree_pipe.sv
// tb/tb_mux_tree_pipe.sv - randomized and directed self-checking bench for mux_tree_pipe
module tb_mux_tree_pipe;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [63:0] a_in;  logic [2:0] a_sel; logic a_iv, a_ir, a_ov, a_or; logic [7:0]  a_out; logic [2:0] a_os;
    logic [63:0] b_in;  logic [2:0] b_sel; logic b_iv, b_ir, b_ov, b_or; logic [7:0]  b_out; logic [2:0] b_os;
    logic [31:0] c_in;  logic [0:0] c_sel; logic c_iv, c_ir, c_ov, c_or; logic [15:0] c_out; logic [0:0] c_os;

    mux_tree_pipe #(.WIDTH(8), .N_IN(8), .RR_MODE(0)) u_a (
        .clk(clk), .rst_n(rst_n), .in(a_in), .sel(a_sel), .in_valid(a_iv), .in_ready(a_ir),
        .out(a_out), .out_sel(a_os), .out_valid(a_ov), .out_ready(a_or));
    mux_tree_pipe #(.WIDTH(8), .N_IN(8), .RR_MODE(1)) u_b (
        .clk(clk), .rst_n(rst_n), .in(b_in), .sel(b_sel), .in_valid(b_iv), .in_ready(b_ir),
        .out(b_out), .out_sel(b_os), .out_valid(b_ov), .out_ready(b_or));
    mux_tree_pipe #(.WIDTH(16), .N_IN(2), .RR_MODE(0)) u_c (
        .clk(clk), .rst_n(rst_n), .in(c_in), .sel(c_sel), .in_valid(c_iv), .in_ready(c_ir),
        .out(c_out), .out_sel(c_os), .out_valid(c_ov), .out_ready(c_or));

    int pass_cnt = 0;
    int total    = 0;

    // Model: per instance, beats in flight oldest first, each with its pipe position
    int          lv [3];
    logic [15:0] bd [3][8];
    int          bs [3][8];
    int          bp [3][8];
    int          cnt [3];
    int          pop_s [3][64];
    int          npop [3];
    bit          acc [3];
    bit          irlow [3];
    int          rr;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic mchk(int m, logic ov, logic [15:0] od, int os, logic ir, logic orr);
        string n;
        bit    eov;
        n   = $sformatf("inst%0d", m);
        eov = (cnt[m] > 0) && (bp[m][0] == lv[m] - 1);
        chk({n, "_out_valid"}, {31'd0, ov}, {31'd0, eov});
        if (eov) begin
            chk({n, "_out"}, {16'd0, od}, {16'd0, bd[m][0]});
            chk({n, "_out_sel"}, os, bs[m][0]);
        end
        chk({n, "_in_ready"}, {31'd0, ir}, {31'd0, (cnt[m] < lv[m]) || orr});
        if (!ir) irlow[m] = 1'b1;
    endtask

    task automatic mstep(int m, logic iv, logic orr, logic [15:0] d, int s);
        int k    = 0;
        int prev = -1;
        int np;
        acc[m] = iv && ((cnt[m] < lv[m]) || orr);
        for (int i = 0; i < cnt[m]; i++) begin
            int p = bp[m][i];
            if (p == lv[m] - 1 && orr) begin
                if (npop[m] < 64) pop_s[m][npop[m]] = bs[m][i];
                npop[m]++;
                prev = -1;
            end else begin
                np = (p == lv[m] - 1 || prev == p + 1) ? p : p + 1;
                bd[m][k] = bd[m][i];
                bs[m][k] = bs[m][i];
                bp[m][k] = np;
                prev = np;
                k++;
            end
        end
        cnt[m] = k;
        if (acc[m]) begin
            bd[m][k] = d;
            bs[m][k] = s;
            bp[m][k] = 0;
            cnt[m]   = k + 1;
        end
    endtask

    task automatic cycle();
        #1;
        mchk(0, a_ov, {8'd0, a_out}, int'(a_os), a_ir, a_or);
        mchk(1, b_ov, {8'd0, b_out}, int'(b_os), b_ir, b_or);
        mchk(2, c_ov, c_out, int'(c_os), c_ir, c_or);
        mstep(0, a_iv, a_or, {8'd0, a_in[int'(a_sel)*8 +: 8]}, int'(a_sel));
        mstep(1, b_iv, b_or, {8'd0, b_in[rr*8 +: 8]}, rr);
        if (acc[1]) rr = (rr + 1) % 8;
        mstep(2, c_iv, c_or, c_in[int'(c_sel)*16 +: 16], int'(c_sel));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        a_iv = 1'b0; b_iv = 1'b0; c_iv = 1'b0;
        #1;
        chk("rst_async_a_valid", {31'd0, a_ov}, 32'd0);
        chk("rst_async_b_valid", {31'd0, b_ov}, 32'd0);
        chk("rst_async_c_valid", {31'd0, c_ov}, 32'd0);
        chk("rst_async_a_out", {24'd0, a_out}, 32'd0);
        for (int m = 0; m < 3; m++) cnt[m] = 0;
        rr = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_a_in_ready", {31'd0, a_ir}, 32'd1);
    endtask

    task automatic idle(int n);
        a_iv = 1'b0; b_iv = 1'b0; c_iv = 1'b0;
        a_or = 1'b1; b_or = 1'b1; c_or = 1'b1;
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int bi;
        lv = '{3, 3, 1};
        for (int m = 0; m < 3; m++) begin cnt[m] = 0; npop[m] = 0; irlow[m] = 1'b0; end
        rr = 0;
        rst_n = 1'b0;
        a_in = '0; a_sel = '0; a_iv = 1'b0; a_or = 1'b1;
        b_in = '0; b_sel = '0; b_iv = 1'b0; b_or = 1'b1;
        c_in = '0; c_sel = '0; c_iv = 1'b0; c_or = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_a_out", {24'd0, a_out}, 32'd0);
        chk("reset_a_out_sel", {29'd0, a_os}, 32'd0);
        chk("reset_a_out_valid", {31'd0, a_ov}, 32'd0);
        chk("reset_a_in_ready", {31'd0, a_ir}, 32'd1);
        chk("reset_c_out_valid", {31'd0, c_ov}, 32'd0);
        chk("reset_c_in_ready", {31'd0, c_ir}, 32'd1);

        // single beat, sel=5
        for (int i = 0; i < 8; i++) a_in[i*8 +: 8] = 8'(i * 17);
        a_sel = 3'd5; a_iv = 1'b1;
        for (int c = 0; c < 5; c++) begin
            cycle();
            a_iv = 1'b0;
            chk("t1_out_valid", {31'd0, a_ov}, {31'd0, c == 2});
            if (c == 2) begin
                chk("t1_out", {24'd0, a_out}, 32'h55);
                chk("t1_out_sel", {29'd0, a_os}, 32'd5);
            end
        end

        // streaming sel 0..7
        for (int c = 0; c < 11; c++) begin
            a_iv  = (c < 8);
            a_sel = 3'(c);
            #1;
            chk("t2_in_ready", {31'd0, a_ir}, 32'd1);
            cycle();
            chk("t2_out_valid", {31'd0, a_ov}, {31'd0, c >= 2 && c < 10});
            if (c >= 2 && c < 10) chk("t2_out", {24'd0, a_out}, 32'((c - 2) * 17));
        end
        idle(3);

        // backpressure, sels 7..0
        npop[0] = 0; irlow[0] = 1'b0; bi = 0;
        for (int c = 0; c < 25; c++) begin
            a_or  = !(c >= 4 && c <= 7);
            a_iv  = (bi < 8);
            a_sel = 3'(7 - bi);
            cycle();
            if (acc[0]) bi++;
        end
        chk("t3_in_ready_dropped", {31'd0, irlow[0]}, 32'd1);
        chk("t3_beats_out", npop[0], 32'd8);
        for (int k = 0; k < 8; k++) chk("t3_order", pop_s[0][k], 7 - k);
        idle(3);

        // round-robin with a 2-cycle gap
        npop[1] = 0; bi = 0;
        for (int c = 0; c < 18; c++) begin
            b_in  = {$urandom, $urandom};
            b_sel = 3'($urandom);
            b_iv  = (bi < 10) && !(c == 4 || c == 5);
            cycle();
            if (acc[1]) bi++;
        end
        chk("t4_beats_out", npop[1], 32'd10);
        for (int k = 0; k < 10; k++) chk("t4_rr_sel", pop_s[1][k], k % 8);
        idle(2);

        // reset with 3 beats in flight
        npop[0] = 0;
        for (int c = 0; c < 3; c++) begin
            a_iv = 1'b1; a_sel = 3'(c + 1);
            cycle();
        end
        do_reset();
        for (int c = 0; c < 4; c++) begin
            a_iv = 1'b0;
            cycle();
            chk("t5_no_stale", {31'd0, a_ov}, 32'd0);
        end
        a_sel = 3'd2; a_iv = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cycle();
            a_iv = 1'b0;
            chk("t5_out_valid", {31'd0, a_ov}, {31'd0, c == 2});
            if (c == 2) chk("t5_out", {24'd0, a_out}, 32'h22);
        end
        chk("t5_beats_out", npop[0], 32'd1);

        // two-input tree, latency 1
        c_in = {16'hCAFE, 16'hBEEF};
        for (int c = 0; c < 6; c++) begin
            c_iv  = 1'b1;
            c_sel = (c % 2 == 0) ? 1'b1 : 1'b0;
            cycle();
            chk("t6_out_valid", {31'd0, c_ov}, 32'd1);
            chk("t6_out", {16'd0, c_out}, (c % 2 == 0) ? 32'hCAFE : 32'hBEEF);
        end
        idle(2);

        // random traffic with a mid-run reset
        for (int c = 0; c < 1500; c++) begin
            a_iv = ($urandom % 4) != 0; a_or = ($urandom % 3) != 0;
            a_in = {$urandom, $urandom}; a_sel = 3'($urandom);
            b_iv = ($urandom % 3) != 0; b_or = ($urandom % 3) != 0;
            b_in = {$urandom, $urandom}; b_sel = 3'($urandom);
            c_iv = ($urandom % 2) != 0; c_or = ($urandom % 4) != 0;
            c_in = $urandom; c_sel = 1'($urandom);
            if (c == 700) do_reset();
            else cycle();
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
